// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and width helpers for spi_master_ext
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  function automatic int addr_w(input int slaves);
    return slaves > 1 ? $clog2(slaves) : 1;
  endfunction
  function automatic int len_w(input int d_width);
    return $clog2(d_width + 1);
  endfunction
endpackage

// File: rtl/spi_master_ext_clkgen.sv
// spi_clkgen: sclk half-period counter; flags the leading/trailing edge about to be produced
module spi_clkgen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 idle,
  input  logic                 cpol,
  input  logic                 cpol_q,
  input  logic                 start,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sclk,
  output logic                 lead_pulse,
  output logic                 trail_pulse
);
  logic [DIV_WIDTH-1:0] cnt;
  logic tick;
  always_comb begin
    tick = start || (run && cnt == div);
    lead_pulse = tick && sclk == cpol_q;
    trail_pulse = tick && sclk != cpol_q;
  end
  always_ff @(posedge clock) begin
    if (!reset_n || idle) begin
      sclk <= cpol;
      cnt <= '0;
    end else begin
      sclk <= tick ? !sclk : sclk;
      cnt <= (!run || tick) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_master_ext.sv
// spi_master_ext: SPI master with runtime word length, bit order, chip-select delays
// and back-to-back continuous words; transfer settings are latched at start.
module spi_master_ext
  import spi_pkg::*;
#(
  parameter int SLAVES = 1,
  parameter int D_WIDTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter int DLY_WIDTH = 8,
  localparam int ADDR_W = addr_w(SLAVES),
  localparam int LEN_W = len_w(D_WIDTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic                 cont,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic [LEN_W-1:0]     xfer_bits,
  input  logic [DLY_WIDTH-1:0] cs_setup,
  input  logic [DLY_WIDTH-1:0] cs_hold,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [D_WIDTH-1:0]   tx_data,
  input  logic                 miso,
  output logic                 sclk,
  output logic [SLAVES-1:0]    ss_n,
  output logic                 mosi,
  output logic                 busy,
  output logic                 tx_ready,
  output logic [D_WIDTH-1:0]   rx_data,
  output logic                 rx_valid
);
  localparam int E_W = LEN_W + 1;
  localparam logic [LEN_W-1:0] NMAX = LEN_W'(D_WIDTH);

  state_t state, state_nx;
  logic cpol_q, cpha_q, lsb_q, cont_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DLY_WIDTH-1:0] setup_q, hold_q, dly;
  logic [ADDR_W-1:0] addr_q;
  logic [D_WIDTH-1:0] tx_q, nxt_data, nd, rx_sr, rx_next, rx_word;
  logic [LEN_W-1:0] n_q, nxt_n, nn, t, pos;
  logic [E_W-1:0] ecnt;
  logic lead, trail, tick, start, run, pen, last, take, ngo, nxt_go, fin, more;
  logic sample, drive, mosi_nx;

  function automatic logic [LEN_W-1:0] eff_n(input logic [LEN_W-1:0] x);
    return (x == '0 || x > NMAX) ? NMAX : x;
  endfunction

  // bit i of the transmit order of an n-bit right-aligned word
  function automatic logic pick(input logic [D_WIDTH-1:0] d, input logic [LEN_W-1:0] n,
                                input logic [LEN_W-1:0] i, input logic lsb);
    logic [LEN_W-1:0] k;
    logic b;
    k = lsb ? i : n - 1'b1 - i;
    b = 1'b0;
    for (int j = 0; j < D_WIDTH; j++) b = (k == LEN_W'(j)) ? d[j] : b;
    return b;
  endfunction

  spi_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .clock(clock),
    .reset_n(reset_n),
    .idle(state == IDLE),
    .cpol(cpol),
    .cpol_q(cpol_q),
    .start(start),
    .run(run),
    .div(div_q),
    .sclk(sclk),
    .lead_pulse(lead),
    .trail_pulse(trail)
  );

  always_comb begin
    busy = state != IDLE;
    start = state == SETUP && dly == setup_q;
    // after a final edge with no continuation, sclk stays parked until HOLD
    run = state == SHIFT && !(fin && !more);
    tick = lead || trail;
    t = ecnt[E_W-1:1];
    pen = tick && ecnt == {n_q - 1'b1, 1'b0};
    last = tick && ecnt == {n_q - 1'b1, 1'b1};
    take = tx_ready && enable;
    ngo = nxt_go || take;
    nd = nxt_go ? nxt_data : tx_data;
    nn = nxt_go ? nxt_n : eff_n(xfer_bits);
    pos = lsb_q ? t : n_q - 1'b1 - t;
    sample = cpha_q ? trail : lead;
    drive = cpha_q ? lead : trail;
    rx_next = rx_sr;
    for (int j = 0; j < D_WIDTH; j++) rx_next[j] = (sample && pos == LEN_W'(j)) ? miso : rx_sr[j];
    // cpha=0 trailing edges present the following bit, or the next word's first bit
    mosi_nx = cpha_q ? pick(tx_q, n_q, t, lsb_q) :
              (t + 1'b1 < n_q) ? pick(tx_q, n_q, t + 1'b1, lsb_q) :
              ngo ? pick(nd, nn, '0, lsb_q) : mosi;
    state_nx = (state == IDLE && enable) ? SETUP :
               start ? SHIFT :
               (state == SHIFT && fin && !more) ? HOLD :
               (state == HOLD && dly == hold_q) ? IDLE : state;
    for (int j = 0; j < SLAVES; j++) ss_n[j] = !(busy && addr_q == ADDR_W'(j));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      dly <= '0;
      mosi <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= '0;
      rx_sr <= '0;
      rx_word <= '0;
      ecnt <= '0;
      fin <= 1'b0;
      more <= 1'b0;
      nxt_go <= 1'b0;
      nxt_data <= '0;
      nxt_n <= '0;
      tx_q <= '0;
      n_q <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
      lsb_q <= 1'b0;
      cont_q <= 1'b0;
      div_q <= '0;
      setup_q <= '0;
      hold_q <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nx;
      dly <= (state_nx != state) ? '0 : dly + 1'b1;
      tx_ready <= pen && cont_q;
      rx_valid <= fin;
      fin <= last;
      if (fin) rx_data <= rx_word;
      if (state == IDLE && enable) begin
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q <= lsb_first;
        cont_q <= cont;
        div_q <= clk_div;
        setup_q <= cs_setup;
        hold_q <= cs_hold;
        addr_q <= addr;
        tx_q <= tx_data;
        n_q <= eff_n(xfer_bits);
        mosi <= pick(tx_data, eff_n(xfer_bits), '0, lsb_first);
        ecnt <= '0;
        rx_sr <= '0;
        nxt_go <= 1'b0;
      end
      if (tick) begin
        ecnt <= ecnt + 1'b1;
        rx_sr <= rx_next;
      end
      if (drive) mosi <= mosi_nx;
      if (take) begin
        nxt_go <= 1'b1;
        nxt_data <= tx_data;
        nxt_n <= eff_n(xfer_bits);
      end
      // final edge: bank the received word and swap in a pending continuation word
      if (last) begin
        more <= ngo;
        nxt_go <= 1'b0;
        rx_word <= rx_next;
        rx_sr <= '0;
        ecnt <= '0;
        if (ngo) begin
          tx_q <= nd;
          n_q <= nn;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_master_ext.sv
// tb_spi_master_ext: directed SPI transfers with a received-word scoreboard and line-level monitor
module tb_spi_master_ext;
  import spi_pkg::*;

  logic clock = 1'b0;
  logic reset_n, enable, cpol, cpha, lsb_first, cont, miso, loop, mi;
  logic [15:0] clk_div;
  logic [3:0] xfer_bits;
  logic [7:0] cs_setup, cs_hold, tx_data, rx_data;
  logic [1:0] addr;
  logic sclk, mosi, busy, tx_ready, rx_valid;
  logic [3:0] ss_n;

  logic [7:0] sb[$];
  int n_cmp = 0, n_bad = 0;
  int edges, samp_n, pre, post, since, gmin, gmax, busy_n, busy_rise, bad_ss, txr_n, rxv_n;
  logic [31:0] mseq;
  logic prev_sclk = 1'b0, prev_busy = 1'b0;
  logic [3:0] exp_ss = 4'b1110;

  always #5 clock = ~clock;
  assign miso = loop ? mosi : mi;

  spi_master_ext #(.SLAVES(4), .D_WIDTH(8), .DIV_WIDTH(16), .DLY_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .cont(cont), .clk_div(clk_div), .xfer_bits(xfer_bits),
    .cs_setup(cs_setup), .cs_hold(cs_hold), .addr(addr), .tx_data(tx_data), .miso(miso),
    .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .busy(busy), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: line activity counters and the rx_data scoreboard
  always @(negedge clock) begin
    if (sclk != prev_sclk) begin
      if (edges > 0) begin
        gmin = (since + 1 < gmin) ? since + 1 : gmin;
        gmax = (since + 1 > gmax) ? since + 1 : gmax;
      end
      edges++;
      since = 0;
      post = 0;
      if (sclk == (cpol == cpha)) begin
        samp_n++;
        mseq = {mseq[30:0], mosi};
      end
    end else begin
      since++;
      if (~&ss_n) begin
        if (edges == 0) pre++;
        else post++;
      end
    end
    prev_sclk = sclk;
    if (busy) busy_n++;
    if (busy && !prev_busy) busy_rise++;
    prev_busy = busy;
    if (busy && ss_n != exp_ss) bad_ss++;
    if (tx_ready) txr_n++;
    if (rx_valid) begin
      rxv_n++;
      if (sb.size() == 0) chk("rx_valid_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
      else chk("rx_data", 32'(rx_data), 32'(sb.pop_front()));
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clr();
    edges = 0; samp_n = 0; pre = 0; post = 0; since = 0; gmin = 1000; gmax = 0;
    busy_n = 0; busy_rise = 0; bad_ss = 0; txr_n = 0; rxv_n = 0; mseq = 0;
  endtask

  task automatic cfg(input logic [1:0] mode, input logic lsb, input logic c, input logic [15:0] div,
                     input logic [3:0] bits, input logic [7:0] su, input logic [7:0] ho,
                     input logic [1:0] a, input logic lp, input logic m);
    {cpol, cpha} = mode;
    lsb_first = lsb; cont = c; clk_div = div; xfer_bits = bits;
    cs_setup = su; cs_hold = ho; addr = a; loop = lp; mi = m;
    step();
    step();
    clr();
  endtask

  task automatic go(input logic [7:0] d, input logic [7:0] exp_rx, input bit push);
    tx_data = d;
    enable = 1'b1;
    if (push) sb.push_back(exp_rx);
    step();
    enable = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 3000 && busy; k++) step();
    chk("transfer_done", 32'(busy), 32'd0);
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    reset_n = 1'b0; enable = 1'b0; tx_data = 8'h00; loop = 1'b0; mi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; cont = 1'b0; clk_div = 16'd0;
    xfer_bits = 4'd8; cs_setup = 8'd0; cs_hold = 8'd0; addr = 2'd0;
    clr();
    repeat (3) step();
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_ss_n", 32'(ss_n), 32'hF);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    reset_n = 1'b1;
    step();

    // mode 3, msb-first loopback of 0x1B
    cfg(MODE3, 1'b0, 1'b0, 16'd0, 4'd8, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    chk("m3_sclk_idle", 32'(sclk), 32'd1);
    go(8'h1B, 8'h1B, 1'b1);
    wait_done();
    chk("m3_edges", edges, 16);
    chk("m3_sample_edges", samp_n, 8);
    chk("m3_mosi_seq", mseq, 32'h1B);
    chk("m3_rx_valid_cnt", rxv_n, 1);
    chk("m3_busy_cycles", busy_n, 18);
    chk("m3_setup_cycles", pre, 1);
    chk("m3_hold_cycles", post, 1);
    chk("m3_sclk_park", 32'(sclk), 32'd1);

    // mode 0, lsb-first, 5-bit word, miso held high
    cfg(MODE0, 1'b1, 1'b0, 16'd0, 4'd5, 8'd0, 8'd0, 2'd0, 1'b0, 1'b1);
    go(8'h16, 8'h1F, 1'b1);
    wait_done();
    chk("m0_edges", edges, 10);
    chk("m0_mosi_seq", mseq, 32'h0D);
    chk("m0_rx_valid_cnt", rxv_n, 1);

    // continuous: 0xA5 then 0x3C without releasing ss_n
    cfg(MODE0, 1'b0, 1'b1, 16'd0, 4'd8, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    go(8'hA5, 8'hA5, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (tx_ready) found = 1'b1;
      else step();
    end
    chk("cont_tx_ready_seen", 32'(found), 32'd1);
    tx_data = 8'h3C;
    enable = 1'b1;
    sb.push_back(8'h3C);
    step();
    enable = 1'b0;
    wait_done();
    chk("cont_edges", edges, 32);
    chk("cont_rx_valid_cnt", rxv_n, 2);
    chk("cont_ss_glitch", bad_ss, 0);
    chk("cont_busy_rise", busy_rise, 1);
    chk("cont_mosi_seq", mseq, 32'hA53C);
    chk("cont_tx_ready_cnt", txr_n, 2);

    // divider and chip-select delays
    cfg(MODE0, 1'b0, 1'b0, 16'd3, 4'd8, 8'd2, 8'd4, 2'd0, 1'b1, 1'b0);
    go(8'h5A, 8'h5A, 1'b1);
    wait_done();
    chk("dly_edges", edges, 16);
    chk("dly_setup_cycles", pre, 3);
    chk("dly_hold_cycles", post, 5);
    chk("dly_half_min", gmin, 4);
    chk("dly_half_max", gmax, 4);

    // slave 2, addr change and enable pulse mid-transfer ignored
    cfg(MODE1, 1'b0, 1'b0, 16'd1, 4'd8, 8'd0, 8'd0, 2'd2, 1'b1, 1'b0);
    exp_ss = 4'b1011;
    go(8'hC3, 8'hC3, 1'b1);
    repeat (4) step();
    addr = 2'd0;
    tx_data = 8'hFF;
    enable = 1'b1;
    step();
    enable = 1'b0;
    wait_done();
    chk("addr_ss_bad", bad_ss, 0);
    chk("addr_busy_rise", busy_rise, 1);
    chk("addr_rx_valid_cnt", rxv_n, 1);
    chk("addr_ss_release", 32'(ss_n), 32'hF);
    exp_ss = 4'b1110;

    // reset at the 5th edge aborts, then a fresh transfer completes
    cfg(MODE2, 1'b0, 1'b0, 16'd1, 4'd8, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    go(8'h96, 8'h00, 1'b0);
    for (int k = 0; k < 200 && edges < 5; k++) step();
    chk("abort_edges_reached", edges, 5);
    reset_n = 1'b0;
    step();
    chk("abort_ss_n", 32'(ss_n), 32'hF);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sclk", 32'(sclk), 32'd1);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    reset_n = 1'b1;
    repeat (3) step();
    chk("abort_rx_valid_cnt", rxv_n, 0);
    cfg(MODE2, 1'b0, 1'b0, 16'd1, 4'd8, 8'd0, 8'd0, 2'd0, 1'b1, 1'b0);
    go(8'h96, 8'h96, 1'b1);
    wait_done();
    chk("post_abort_edges", edges, 16);
    chk("post_abort_rx_valid_cnt", rxv_n, 1);
    chk("post_abort_mosi_seq", mseq, 32'h96);

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
